// File: rtl/instr_pair_buffer_if.sv
// Bundle for the fetch-side and issue-side pair handshakes of instr_pair_buffer.
// The master drives fetch pairs, decode ready and flush; the slave is the buffer.
interface instr_pair_buffer_if #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 11
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          fetch_valid;
    logic [IW-1:0] fetch_instr1;
    logic [IW-1:0] fetch_instr2;
    logic [AW-1:0] fetch_pc;
    logic          enable_pc;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_instr1;
    logic [IW-1:0] issue_instr2;
    logic [AW-1:0] issue_pc;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output fetch_valid, fetch_instr1, fetch_instr2, fetch_pc, issue_ready, flush,
        input  enable_pc, issue_valid, issue_instr1, issue_instr2, issue_pc, count
    );

    modport slave (
        input  fetch_valid, fetch_instr1, fetch_instr2, fetch_pc, issue_ready, flush,
        output enable_pc, issue_valid, issue_instr1, issue_instr2, issue_pc, count
    );
endinterface

// File: rtl/instr_pair_buffer.sv
// Small in-order FIFO of instruction pairs between dual-issue fetch and decode.
// Fetch advances only on a capture (enable_pc); flush drops every queued pair.
module instr_pair_buffer #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int AW    = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_pair_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] instr1_q [DEPTH];
    logic [IW-1:0] instr2_q [DEPTH];
    logic [AW-1:0] pc_q     [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic not_empty;
    logic push;
    logic pop;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);

    // No full pass-through: a pop in the same cycle never frees a slot for fetch.
    assign push = bus.fetch_valid & ~full & ~bus.flush & ~reset;
    assign pop  = not_empty & bus.issue_ready & ~bus.flush;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (push) wp_d = wp_q + PW'(1);
        if (pop)  rp_d = rp_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr1_q[i] <= '0;
                instr2_q[i] <= '0;
                pc_q[i]     <= '0;
            end
        end else if (bus.flush) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            if (push) begin
                instr1_q[wp_q] <= bus.fetch_instr1;
                instr2_q[wp_q] <= bus.fetch_instr2;
                pc_q[wp_q]     <= bus.fetch_pc;
            end
        end
    end

    assign bus.enable_pc    = push;
    assign bus.issue_valid  = not_empty;
    assign bus.issue_instr1 = not_empty ? instr1_q[rp_q] : '0;
    assign bus.issue_instr2 = not_empty ? instr2_q[rp_q] : '0;
    assign bus.issue_pc     = not_empty ? pc_q[rp_q]     : '0;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_instr_pair_buffer.sv
// Directed bench for instr_pair_buffer: reset, fill, drain, wrap, flush and bubbles.
module tb_instr_pair_buffer;
    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int AW    = 11;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [AW-1:0] sb [$];

    instr_pair_buffer_if #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) bus ();

    instr_pair_buffer #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk_i1(input logic [AW-1:0] pc);
        return 32'h1000_0000 | {21'h0, pc};
    endfunction

    function automatic logic [IW-1:0] mk_i2(input logic [AW-1:0] pc);
        return 32'h2000_0000 | {21'h0, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [AW-1:0] pc);
        bus.fetch_valid  = v;
        bus.fetch_pc     = pc;
        bus.fetch_instr1 = mk_i1(pc);
        bus.fetch_instr2 = mk_i2(pc);
    endtask

    task automatic chk_head(input string tag, input logic [AW-1:0] pc);
        chk({tag, "_valid"}, 64'(bus.issue_valid), 64'd1);
        chk({tag, "_pc"},    64'(bus.issue_pc),    64'(pc));
        chk({tag, "_i1"},    64'(bus.issue_instr1), 64'(mk_i1(pc)));
        chk({tag, "_i2"},    64'(bus.issue_instr2), 64'(mk_i2(pc)));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 64'(bus.count),        64'd0);
        chk({tag, "_valid"}, 64'(bus.issue_valid),  64'd0);
        chk({tag, "_pc"},    64'(bus.issue_pc),     64'd0);
        chk({tag, "_i1"},    64'(bus.issue_instr1), 64'd0);
        chk({tag, "_i2"},    64'(bus.issue_instr2), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] pc;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.issue_ready = 1'b0;
        bus.flush       = 1'b0;
        set_fetch(1'b1, 11'h000);

        // Reset held two cycles with fetch_valid high.
        settle();
        chk("rst_en0", 64'(bus.enable_pc), 64'd0);
        tick();
        chk("rst_en1", 64'(bus.enable_pc), 64'd0);
        tick();
        reset = 1'b0;
        settle();
        chk_empty("post_rst");
        chk("post_rst_en", 64'(bus.enable_pc), 64'd1);

        // Fill to full with decode stalled.
        for (int k = 0; k < DEPTH; k++) begin
            set_fetch(1'b1, AW'(8 * k));
            settle();
            chk("fill_en", 64'(bus.enable_pc), 64'd1);
            tick();
            chk("fill_count", 64'(bus.count), 64'(k + 1));
            chk_head("fill_head", 11'h000);
        end
        set_fetch(1'b1, 11'h020);
        settle();
        chk("full_en", 64'(bus.enable_pc), 64'd0);
        tick();
        chk("full_count", 64'(bus.count), 64'd4);

        // Drain: first cycle full with fetch still valid (pop, no push), then a 3-cycle bubble.
        bus.issue_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0) set_fetch(1'b0, 11'h020);
            settle();
            chk("drain_en", 64'(bus.enable_pc), 64'd0);
            chk_head("drain_head", AW'(8 * k));
            tick();
            chk("drain_count", 64'(bus.count), 64'(DEPTH - 1 - k));
        end
        chk_empty("drained");

        // Build count=2, then push+pop together for 10 cycles across pointer wrap.
        bus.issue_ready = 1'b0;
        pc = 11'h100;
        for (int k = 0; k < 2; k++) begin
            set_fetch(1'b1, pc);
            sb.push_back(pc);
            pc = pc + 11'd8;
            tick();
        end
        chk("pp_pre_count", 64'(bus.count), 64'd2);
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_fetch(1'b1, pc);
            settle();
            chk("pp_en", 64'(bus.enable_pc), 64'd1);
            chk_head("pp_head", sb[0]);
            sb.push_back(pc);
            void'(sb.pop_front());
            pc = pc + 11'd8;
            tick();
            chk("pp_count", 64'(bus.count), 64'd2);
        end

        // Reach count=3, then flush with decode ready.
        bus.issue_ready = 1'b0;
        set_fetch(1'b1, pc);
        sb.push_back(pc);
        tick();
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        chk_head("pre_flush_head", sb[0]);
        bus.issue_ready = 1'b1;
        bus.flush = 1'b1;
        set_fetch(1'b1, 11'h1F8);
        settle();
        chk("flush_en", 64'(bus.enable_pc), 64'd0);
        tick();
        bus.flush = 1'b0;
        sb.delete();
        chk_empty("post_flush");
        bus.issue_ready = 1'b0;
        set_fetch(1'b1, 11'h200);
        settle();
        chk("after_flush_en", 64'(bus.enable_pc), 64'd1);
        tick();
        chk("after_flush_count", 64'(bus.count), 64'd1);
        chk_head("after_flush_head", 11'h200);

        // Reset mid-operation clears queue and storage.
        set_fetch(1'b1, 11'h208);
        tick();
        chk("pre_rst2_count", 64'(bus.count), 64'd2);
        reset = 1'b1;
        settle();
        chk("rst2_en", 64'(bus.enable_pc), 64'd0);
        tick();
        reset = 1'b0;
        set_fetch(1'b0, 11'h000);
        settle();
        chk_empty("post_rst2");
        chk("post_rst2_en", 64'(bus.enable_pc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_pair_buffer.md
# instr_pair_buffer

Decoupling buffer on the consumer side of the dual-issue instruction fetch stage. Fetch presents an even/odd instruction pair and its byte address combinationally every cycle. This block captures pairs into a small FIFO and drives `enable_pc` back to fetch, so fetch advances only when a pair is actually taken. It then hands pairs in order to decode/issue over a valid/ready handshake and discards all queued pairs on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 4: number of pair entries; power of two, ≥ 2.
- `IW`, 32: instruction width.
- `AW`, 11: instruction byte-address width; matches the fetch PC.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `fetch_valid`  in  1  fetch pair on `fetch_instr1/2` and `fetch_pc` is meaningful this cycle.
- `fetch_instr1`  in  IW  first (even-slot) instruction of the pair.
- `fetch_instr2`  in  IW  second (odd-slot) instruction of the pair.
- `fetch_pc`  in  AW  byte address of `fetch_instr1`.
- `enable_pc`  out  1  pair is captured at this edge; fetch advances PC by 8.
- `issue_valid`  out  1  head entry is valid.
- `issue_ready`  in  1  decode accepts the head pair.
- `issue_instr1`  out  IW  head pair, first instruction.
- `issue_instr2`  out  IW  head pair, second instruction.
- `issue_pc`  out  AW  head pair address.
- `flush`  in  1  discard all queued pairs; branch redirect or mispredict.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: circular array of DEPTH entries {instr1, instr2, pc}, write pointer `wp`, read pointer `rp`, occupancy `count`.
- Push condition: `enable_pc = fetch_valid & (count != DEPTH) & ~flush & ~reset`. This is combinational. On a push edge the entry at `wp` is written and `wp` increments modulo DEPTH.
- Pop condition: `pop = issue_valid & issue_ready & ~flush`. On a pop edge `rp` increments modulo DEPTH.
- Occupancy update: push only gives +1. Pop only gives −1. Push and pop together leave `count` unchanged.
- Full: `count == DEPTH`. No push occurs, even if a pop happens in the same cycle; there is no full pass-through.
- Empty: `count == 0`. `issue_valid` is 0, and `issue_*` data is driven to zero. There is no fetch-to-issue bypass.
- Output: `issue_valid = (count != 0)`. `issue_*` is driven combinationally from entry `rp`.
- Flush: takes priority over push and pop. On the flush edge `wp`, `rp` and `count` all go to 0. During the flush cycle `enable_pc` is 0, so fetch does not advance and no queued pair is counted as issued.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` saturates structurally at DEPTH and never exceeds it.
- Pairs leave in exactly the order they were captured. Pair contents are never reordered or split.

## Timing
- Reset (edge with `reset`=1): `wp`, `rp` and `count` are 0, and every storage entry is cleared to 0. After that edge `issue_valid`=0, `issue_instr1/2`=0, `issue_pc`=0, `count`=0.
- `enable_pc` is 0 while `reset` is high. In the first cycle after reset it equals `fetch_valid`.
- Reset mid-operation behaves exactly like flush plus clearing of the storage contents.
- Latency: a pair captured at edge N appears on `issue_*` with `issue_valid`=1 after edge N (visible in cycle N+1).
- With `issue_ready` held high and `fetch_valid` high, steady state is one pair per cycle and `count` holds at 1.
- `enable_pc` is combinational from `count`, `fetch_valid` and `flush`. It has no combinational dependence on `issue_ready`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `fetch_valid`=1 → during reset `enable_pc`=0. After release `count`=0, `issue_valid`=0, `issue_*`=0, and `enable_pc`=1.
- **Fill to full:** `issue_ready`=0; fetch supplies pc 0x000, 0x008, 0x010, 0x018 → `count` goes 1,2,3,4. `enable_pc` drops to 0 once `count`=4, and pc 0x020 is not captured.
- **Drain order:** from the full state, raise `issue_ready` → `issue_pc` reads 0x000, 0x008, 0x010, 0x018 on consecutive cycles with matching instruction pairs. `issue_valid`=0 afterwards.
- **Simultaneous push/pop and wrap:**
  - At `count`=2 with both push and pop active for 10 cycles → `count` stays 2, ordering is preserved, and the pointers wrap past DEPTH−1 without data corruption.
  - At `count`=4 with `issue_ready`=1 → a pop occurs and no push, so `count`=3.
- **Flush:** at `count`=3 with `issue_ready`=1, assert `flush` for 1 cycle → `enable_pc`=0 and no pop that cycle. Next cycle `count`=0 and `issue_valid`=0; the following pair is then captured normally.
- **Fetch bubble:** drop `fetch_valid` for 3 cycles while draining → no capture, `enable_pc`=0, and `count` decrements to 0 with no spurious entries.
